// File: rtl/common.sv
// Shared core definitions: ALU function encoding used by the execute stage.
package common;

  typedef enum logic [3:0] {
    FUNC_ADD   = 4'd0,
    FUNC_SUB   = 4'd1,
    FUNC_AND   = 4'd2,
    FUNC_OR    = 4'd3,
    FUNC_XOR   = 4'd4,
    FUNC_SLL   = 4'd5,
    FUNC_SRL   = 4'd6,
    FUNC_SRA   = 4'd7,
    FUNC_SLT   = 4'd8,
    FUNC_SLTU  = 4'd9,
    FUNC_PASSB = 4'd10
  } func_t;

endpackage

// File: rtl/stage_ex_pipe.sv
// Execute stage: 1-cycle ALU, MUL_STAGES-deep pipelined multiplier, single output register.
// Optional STAGE_EX_MULH_EN adds in_mul_high / in_mul_signed for upper-half products.
module stage_ex_pipe
  import common::*;
#(
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned MUL_STAGES = 3,
  parameter int unsigned THREAD_W   = 2,
  parameter int unsigned REG_W      = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [THREAD_W-1:0] in_thread,
  input  logic [REG_W-1:0]    in_dst,
  input  logic [WORD_W-1:0]   in_pc,
  input  logic [WORD_W-1:0]   in_r1,
  input  logic [WORD_W-1:0]   in_r2,
  input  logic [WORD_W-1:0]   in_imm,
  input  logic                in_sel_a,
  input  logic                in_sel_b,
  input  func_t               in_alu_func,
  input  logic                in_is_mul,
`ifdef STAGE_EX_MULH_EN
  input  logic                in_mul_high,
  input  logic                in_mul_signed,
`endif
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [THREAD_W-1:0] out_thread,
  output logic [REG_W-1:0]    out_dst,
  output logic [WORD_W-1:0]   out_pc,
  output logic [WORD_W-1:0]   out_data,
  output logic                out_isequal,
  output logic                out_is_mul,
  output logic                busy
);

  localparam int unsigned CNT_W = (MUL_STAGES > 1) ? $clog2(MUL_STAGES) : 1;
  localparam int unsigned SH_W  = $clog2(WORD_W);
  localparam bit          MUL_PIPED = (MUL_STAGES > 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                w_accept;
  logic                w_wr_op;
  logic                w_wr_mul;
  logic [WORD_W-1:0]   w_op_a;
  logic [WORD_W-1:0]   w_op_b;
  logic [WORD_W-1:0]   w_alu_res;
  logic [WORD_W-1:0]   w_mul_res;
  logic [WORD_W-1:0]   w_mul_tail;
  logic [WORD_W-1:0]   w_op_res;
  logic                w_iseq;

  logic [THREAD_W-1:0] r_mul_thread;
  logic [REG_W-1:0]    r_mul_dst;
  logic [WORD_W-1:0]   r_mul_pc;
  logic                r_mul_iseq;

  logic                r_out_valid;
  logic [THREAD_W-1:0] r_out_thread;
  logic [REG_W-1:0]    r_out_dst;
  logic [WORD_W-1:0]   r_out_pc;
  logic [WORD_W-1:0]   r_out_data;
  logic                r_out_isequal;
  logic                r_out_is_mul;

  // Ready only when idle and the output slot is free or draining; flush blocks intake.
  assign in_ready = (r_state == ST_IDLE) && (!r_out_valid || out_ready) && !flush;
  assign w_accept = in_valid && in_ready;
  assign w_iseq   = (in_r1 == in_r2);

  always_comb begin
    w_op_a    = in_sel_a ? in_pc  : in_r1;
    w_op_b    = in_sel_b ? in_imm : in_r2;
    w_alu_res = '0;
    case (in_alu_func)
      FUNC_ADD:   w_alu_res = w_op_a + w_op_b;
      FUNC_SUB:   w_alu_res = w_op_a - w_op_b;
      FUNC_AND:   w_alu_res = w_op_a & w_op_b;
      FUNC_OR:    w_alu_res = w_op_a | w_op_b;
      FUNC_XOR:   w_alu_res = w_op_a ^ w_op_b;
      FUNC_SLL:   w_alu_res = w_op_a << w_op_b[SH_W-1:0];
      FUNC_SRL:   w_alu_res = w_op_a >> w_op_b[SH_W-1:0];
      FUNC_SRA:   w_alu_res = WORD_W'($signed(w_op_a) >>> w_op_b[SH_W-1:0]);
      FUNC_SLT:   w_alu_res = WORD_W'($signed(w_op_a) < $signed(w_op_b));
      FUNC_SLTU:  w_alu_res = WORD_W'(w_op_a < w_op_b);
      FUNC_PASSB: w_alu_res = w_op_b;
      default:    w_alu_res = '0;
    endcase
  end

`ifdef STAGE_EX_MULH_EN
  logic [2*WORD_W-1:0] w_mul_a;
  logic [2*WORD_W-1:0] w_mul_b;
  logic [2*WORD_W-1:0] w_mul_full;

  // Extending both operands to 2*WORD_W makes the truncated product correct for either signedness.
  always_comb begin
    w_mul_a    = in_mul_signed ? {{WORD_W{in_r1[WORD_W-1]}}, in_r1} : {{WORD_W{1'b0}}, in_r1};
    w_mul_b    = in_mul_signed ? {{WORD_W{in_r2[WORD_W-1]}}, in_r2} : {{WORD_W{1'b0}}, in_r2};
    w_mul_full = w_mul_a * w_mul_b;
    w_mul_res  = in_mul_high ? w_mul_full[2*WORD_W-1:WORD_W] : w_mul_full[WORD_W-1:0];
  end
`else
  assign w_mul_res = in_r1 * in_r2;
`endif

  assign w_op_res = (in_is_mul && !MUL_PIPED) ? w_mul_res : w_alu_res;

  generate
    if (MUL_STAGES > 1) begin : g_pipe
      logic [MUL_STAGES-1:0][WORD_W-1:0] r_pipe;
      logic [WORD_W-1:0]                 w_stage0;

      // Stage 0 holds the product captured at accept; later stages shift every cycle.
      assign w_stage0 = (w_accept && in_is_mul) ? w_mul_res : r_pipe[0];

      always_ff @(posedge clk) begin
        r_pipe <= {r_pipe[MUL_STAGES-2:0], w_stage0};
      end

      assign w_mul_tail = r_pipe[MUL_STAGES-1];
    end else begin : g_nopipe
      assign w_mul_tail = w_mul_res;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state: flush wins over accept and completion.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_wr_op     = 1'b0;
    w_wr_mul    = 1'b0;
    if (flush) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (in_is_mul && MUL_PIPED) begin
              w_state_nxt = ST_MUL;
              w_cnt_nxt   = CNT_W'(MUL_STAGES - 1);
            end else begin
              w_wr_op = 1'b1;
            end
          end
        end
        ST_MUL: begin
          if (r_cnt == '0) begin
            w_wr_mul    = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mul_thread <= '0;
      r_mul_dst    <= '0;
      r_mul_pc     <= '0;
      r_mul_iseq   <= 1'b0;
    end else if (w_accept && in_is_mul) begin
      r_mul_thread <= in_thread;
      r_mul_dst    <= in_dst;
      r_mul_pc     <= in_pc;
      r_mul_iseq   <= w_iseq;
    end
  end

  // Output register: data only changes on a write, so it holds while stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid   <= 1'b0;
      r_out_thread  <= '0;
      r_out_dst     <= '0;
      r_out_pc      <= '0;
      r_out_data    <= '0;
      r_out_isequal <= 1'b0;
      r_out_is_mul  <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_wr_op) begin
      r_out_valid   <= 1'b1;
      r_out_thread  <= in_thread;
      r_out_dst     <= in_dst;
      r_out_pc      <= in_pc;
      r_out_data    <= w_op_res;
      r_out_isequal <= w_iseq;
      r_out_is_mul  <= in_is_mul;
    end else if (w_wr_mul) begin
      r_out_valid   <= 1'b1;
      r_out_thread  <= r_mul_thread;
      r_out_dst     <= r_mul_dst;
      r_out_pc      <= r_mul_pc;
      r_out_data    <= w_mul_tail;
      r_out_isequal <= r_mul_iseq;
      r_out_is_mul  <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid   = r_out_valid;
  assign out_thread  = r_out_thread;
  assign out_dst     = r_out_dst;
  assign out_pc      = r_out_pc;
  assign out_data    = r_out_data;
  assign out_isequal = r_out_isequal;
  assign out_is_mul  = r_out_is_mul;
  assign busy        = (r_state == ST_MUL);

endmodule

// File: tb/tb_stage_ex_pipe.sv
// Scoreboard bench for stage_ex_pipe: driver pushes expected results, negedge monitor compares.
module tb_stage_ex_pipe;
  import common::*;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned MUL_STAGES = 3;
  localparam int unsigned THREAD_W   = 2;
  localparam int unsigned REG_W      = 5;

  typedef struct {
    logic [THREAD_W-1:0] thread;
    logic [REG_W-1:0]    dst;
    logic [WORD_W-1:0]   pc, r1, r2, imm;
    logic                sel_a, sel_b;
    func_t               func;
    logic                is_mul, mul_high, mul_signed;
  } op_t;

  typedef struct {
    int unsigned         due;
    logic [THREAD_W-1:0] thread;
    logic [REG_W-1:0]    dst;
    logic [WORD_W-1:0]   pc, data;
    logic                iseq, is_mul;
  } exp_t;

  logic                clk;
  logic                rst;
  logic                in_valid, in_ready;
  logic [THREAD_W-1:0] in_thread;
  logic [REG_W-1:0]    in_dst;
  logic [WORD_W-1:0]   in_pc, in_r1, in_r2, in_imm;
  logic                in_sel_a, in_sel_b;
  func_t               in_alu_func;
  logic                in_is_mul, in_mul_high, in_mul_signed;
  logic                flush;
  logic                out_valid, out_ready;
  logic [THREAD_W-1:0] out_thread;
  logic [REG_W-1:0]    out_dst;
  logic [WORD_W-1:0]   out_pc, out_data;
  logic                out_isequal, out_is_mul, busy;

  stage_ex_pipe #(
    .WORD_W(WORD_W), .MUL_STAGES(MUL_STAGES), .THREAD_W(THREAD_W), .REG_W(REG_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_thread(in_thread), .in_dst(in_dst), .in_pc(in_pc),
    .in_r1(in_r1), .in_r2(in_r2), .in_imm(in_imm),
    .in_sel_a(in_sel_a), .in_sel_b(in_sel_b),
    .in_alu_func(in_alu_func), .in_is_mul(in_is_mul),
`ifdef STAGE_EX_MULH_EN
    .in_mul_high(in_mul_high), .in_mul_signed(in_mul_signed),
`endif
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_thread(out_thread), .out_dst(out_dst), .out_pc(out_pc),
    .out_data(out_data), .out_isequal(out_isequal), .out_is_mul(out_is_mul),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned cyc = 0;
  int unsigned busy_until = 0;
  bit          mon_en = 1'b0;
  exp_t        q[$];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic bit exp_valid();
    return (q.size() != 0) && (cyc >= q[0].due);
  endfunction

  function automatic bit model_rdy();
    return (cyc >= busy_until) && (!exp_valid() || out_ready) && !flush;
  endfunction

  // Reference result straight from the operation's definition.
  function automatic logic [31:0] model_res(op_t o);
    logic [31:0] a, b;
    logic [63:0] p;
    if (o.is_mul) begin
      p = 64'(o.r1) * 64'(o.r2);
`ifdef STAGE_EX_MULH_EN
      if (o.mul_signed) p = 64'(longint'($signed(o.r1)) * longint'($signed(o.r2)));
      if (o.mul_high) return p[63:32];
`endif
      return p[31:0];
    end
    a = o.sel_a ? o.pc : o.r1;
    b = o.sel_b ? o.imm : o.r2;
    case (o.func)
      FUNC_ADD:   return a + b;
      FUNC_SUB:   return a - b;
      FUNC_AND:   return a & b;
      FUNC_OR:    return a | b;
      FUNC_XOR:   return a ^ b;
      FUNC_SLL:   return a << b[4:0];
      FUNC_SRL:   return a >> b[4:0];
      FUNC_SRA:   return 32'($signed(a) >>> b[4:0]);
      FUNC_SLT:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      FUNC_SLTU:  return (a < b) ? 32'd1 : 32'd0;
      FUNC_PASSB: return b;
      default:    return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  function automatic op_t rand_op();
    op_t o;
    o.thread     = 2'($urandom);
    o.dst        = 5'($urandom);
    o.pc         = $urandom;
    o.r1         = pick();
    o.r2         = ($urandom_range(0, 3) == 0) ? o.r1 : pick();
    o.imm        = pick();
    o.sel_a      = 1'($urandom);
    o.sel_b      = 1'($urandom);
    o.func       = func_t'(4'($urandom_range(0, 10)));
    o.is_mul     = ($urandom_range(0, 2) == 0);
    o.mul_high   = 1'($urandom);
    o.mul_signed = 1'($urandom);
    return o;
  endfunction

  // One clock cycle: drive, decide acceptance from the model, update the model after the edge.
  task automatic step(input bit v, input op_t o, input bit ordy, input bit fl, output bit acc);
    exp_t e;
    in_valid      = v;
    in_thread     = o.thread;
    in_dst        = o.dst;
    in_pc         = o.pc;
    in_r1         = o.r1;
    in_r2         = o.r2;
    in_imm        = o.imm;
    in_sel_a      = o.sel_a;
    in_sel_b      = o.sel_b;
    in_alu_func   = o.func;
    in_is_mul     = o.is_mul;
    in_mul_high   = o.mul_high;
    in_mul_signed = o.mul_signed;
    out_ready     = ordy;
    flush         = fl;
    acc = v && model_rdy();
    @(posedge clk);
    cyc++;
    if (fl) begin
      q.delete();
      busy_until = 0;
    end
    if (acc) begin
      e.thread = o.thread;
      e.dst    = o.dst;
      e.pc     = o.pc;
      e.data   = model_res(o);
      e.iseq   = (o.r1 == o.r2);
      e.is_mul = o.is_mul;
      e.due    = cyc;
      if (o.is_mul && MUL_STAGES > 1) begin
        e.due      = cyc + MUL_STAGES;
        busy_until = cyc + MUL_STAGES;
      end
      q.push_back(e);
    end
    #1;
  endtask

  task automatic drive_until_acc(input op_t o, input bit ordy);
    bit acc;
    int n;
    n = 0;
    do begin
      step(1'b1, o, ordy, 1'b0, acc);
      n++;
    end while (!acc && n < 50);
    chk("accept_within_bound", 32'(acc), 32'd1);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, rand_op(), 1'b1, 1'b0, acc);
  endtask

  // Monitor: timing of out_valid/busy/in_ready plus payload against the queue front.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("out_valid", 32'(out_valid), 32'(exp_valid()));
      chk("busy", 32'(busy), 32'(cyc < busy_until));
      chk("in_ready", 32'(in_ready), 32'(model_rdy()));
      if (out_valid && exp_valid()) begin
        chk("out_data", out_data, q[0].data);
        chk("out_pc", out_pc, q[0].pc);
        chk("out_thread", 32'(out_thread), 32'(q[0].thread));
        chk("out_dst", 32'(out_dst), 32'(q[0].dst));
        chk("out_isequal", 32'(out_isequal), 32'(q[0].iseq));
        chk("out_is_mul", 32'(out_is_mul), 32'(q[0].is_mul));
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $fatal(1);
  end

  initial begin
    op_t o, o2;
    bit  acc;
    rst = 1'b0;
    in_valid = 1'b0; in_thread = '0; in_dst = '0; in_pc = '0; in_r1 = '0; in_r2 = '0;
    in_imm = '0; in_sel_a = 1'b0; in_sel_b = 1'b0; in_alu_func = FUNC_ADD; in_is_mul = 1'b0;
    in_mul_high = 1'b0; in_mul_signed = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b1;
    mon_en = 1'b1;

    // ADD 5 + 7
    o = rand_op(); o.is_mul = 1'b0; o.func = FUNC_ADD; o.sel_a = 1'b0; o.sel_b = 1'b0;
    o.r1 = 32'd5; o.r2 = 32'd7;
    drive_until_acc(o, 1'b1);

    // pc + imm held by backpressure for 3 cycles, then released
    o = rand_op(); o.is_mul = 1'b0; o.func = FUNC_ADD; o.sel_a = 1'b1; o.sel_b = 1'b1;
    o.pc = 32'h100; o.imm = 32'd4;
    drive_until_acc(o, 1'b1);
    o2 = rand_op(); o2.is_mul = 1'b0;
    repeat (3) step(1'b1, o2, 1'b0, 1'b0, acc);
    drive_until_acc(o2, 1'b1);

    // multiply followed immediately by an ADD
    o = rand_op(); o.is_mul = 1'b1; o.mul_high = 1'b0; o.r1 = 32'hFFFF_FFFF; o.r2 = 32'd2;
    drive_until_acc(o, 1'b1);
    o2 = rand_op(); o2.is_mul = 1'b0; o2.func = FUNC_ADD;
    drive_until_acc(o2, 1'b1);
    idle(3);

    // flush one cycle after multiply accept
    drive_until_acc(o, 1'b1);
    step(1'b1, o2, 1'b1, 1'b1, acc);
    idle(MUL_STAGES + 2);

    // asynchronous reset in the middle of a multiply
    drive_until_acc(o, 1'b1);
    idle(1);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    q.delete();
    busy_until = 0;
    idle(2);
    rst = 1'b1;
    idle(MUL_STAGES + 2);

`ifdef STAGE_EX_MULH_EN
    o = rand_op(); o.is_mul = 1'b1; o.mul_high = 1'b1; o.mul_signed = 1'b1;
    o.r1 = 32'hFFFF_FFFE; o.r2 = 32'd3;
    drive_until_acc(o, 1'b1);
    o.mul_signed = 1'b0;
    drive_until_acc(o, 1'b1);
    idle(MUL_STAGES + 2);
`endif

    // randomized traffic with backpressure and occasional flush
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 3) != 0), rand_op(), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 24) == 0), acc);
    end

    idle(MUL_STAGES + 20);
    chk("drain_queue_empty", 32'(q.size()), 32'd0);
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
